// File: rtl/router_defs.sv
// Shared definitions for the router packet path:
// header field layout, length limits and source FSM states.
package router_defs;

    localparam int LEN_W     = 6;
    localparam int ADDR_W    = 2;
    localparam int MAX_LEN   = 63;
    localparam int BUF_DEPTH = MAX_LEN + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    function automatic logic [7:0] make_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_src_buf.sv
// Payload store for the packet source: 64 bytes,
// synchronous write, combinational read.
module router_src_buf
    import router_defs::*;
(
    input  logic       clock,
    input  logic       wen,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [BUF_DEPTH];

    // Write port: one byte per enabled edge
    always_ff @(posedge clock) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_src.sv
// Store-and-forward packet source feeding the router input:
// buffers the payload, then streams header, payload and parity.
module router_pkt_src
    import router_defs::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int ADDR_LIMIT = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
    output logic       req_ready,
    input  logic [7:0] pay_data,
    input  logic       pay_valid,
    output logic       pay_ready,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       done,
    output logic       err
);

    state_t     state;
    logic [5:0] len_q;
    logic [7:0] hdr;
    logic [7:0] parity;
    logic [5:0] wcnt;
    logic [5:0] rcnt;
    logic [3:0] gcnt;
    logic       wen;
    logic [5:0] raddr;
    logic [7:0] rdata;

    assign req_ready = (state == S_IDLE);
    assign pay_ready = (state == S_LOAD);
    assign wen       = pay_ready && pay_valid;
    // HEADER reads byte 0; PAYLOAD prefetches the next byte
    assign raddr     = (state == S_PAYLOAD) ? rcnt + 6'd1 : 6'd0;

    router_src_buf u_buf (
        .clock (clock),
        .wen   (wen),
        .waddr (wcnt),
        .wdata (pay_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Request, load and transmit sequencing with registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            len_q     <= '0;
            hdr       <= '0;
            parity    <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            gcnt      <= '0;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (int'(dest_addr) >= ADDR_LIMIT || pay_len == 6'd0) begin
                            err <= 1'b1;
                        end else begin
                            len_q  <= pay_len;
                            hdr    <= make_header(pay_len, dest_addr);
                            parity <= make_header(pay_len, dest_addr);
                            wcnt   <= '0;
                            state  <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (pay_valid) begin
                        parity <= parity ^ pay_data;
                        wcnt   <= wcnt + 6'd1;
                        if (wcnt == len_q - 6'd1) begin
                            data_out  <= hdr;
                            pkt_valid <= 1'b1;
                            rcnt      <= '0;
                            state     <= S_HEADER;
                        end
                    end
                end
                S_HEADER: begin
                    if (!busy) begin
                        data_out <= rdata;
                        state    <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        if (rcnt != len_q - 6'd1) begin
                            data_out <= rdata;
                            rcnt     <= rcnt + 6'd1;
                        end else begin
                            data_out  <= parity;
                            pkt_valid <= 1'b0;
                            state     <= S_PARITY;
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        data_out <= '0;
                        done     <= 1'b1;
                        gcnt     <= '0;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gcnt == 4'(GAP_CYCLES - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        gcnt <= gcnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
